muldiv_sched: RTL and testbench
===============================

// Module: muldiv_sched
// PURPOSE
//  Issue-side scheduler for the M-extension unit. Takes one op/cycle from the mul/div
//  reservation station and steers MUL* into a MUL_LAT-deep pipelined multiplier and
//  DIV/REM* into one iterative radix-2 divider. Merges both onto a single CDB writeback
//  port tagged with the ROB index. Supports flush on branch mispredict.
// PARAMETERS
//  XLEN     32  operand/result width
//  TAG_W    6   ROB tag width
//  MUL_LAT  2   multiplier accept->writeback cycles (>=1)
// PORTS
//  clk_i        in   1       clock
//  reset_i      in   1       synchronous reset, active-low
//  flush_i      in   1       kill all in-flight ops
//  req_valid_i  in   1       request valid
//  req_ready_o  out  1       request accepted when valid&ready
//  funct3_i     in   3       M-ext funct3 (000 MUL..111 REMU)
//  rs1_i        in   XLEN    operand 1
//  rs2_i        in   XLEN    operand 2
//  tag_i        in   TAG_W   ROB tag
//  wb_valid_o   out  1       writeback valid (CDB always accepts)
//  wb_tag_o     out  TAG_W   writeback tag
//  wb_value_o   out  XLEN    writeback result
//  div_busy_o   out  1       divider FSM not IDLE
// BEHAVIOUR
//  Clock is clk_i; reset_i is synchronous, active-low. While reset_i=0 at an edge:
//   FSM->IDLE, all valid bits 0; wb_valid_o=0, div_busy_o=0, req_ready_o=0.
//   wb_tag_o/wb_value_o are don't-care while wb_valid_o=0.
//  req_ready_o = reset_i & ~flush_i & (funct3_i[2]==0 | state==IDLE).
//   MUL ops are never stalled; DIV ops wait for an IDLE divider.
//  MUL path: MUL_LAT-stage shift of {valid,tag,hi_sel,33b operands}.
//   MUL=low 32 of u*u; MULH=s*s hi; MULHSU=s*u hi; MULHU=u*u hi.
//   Op accepted at edge E appears on wb at cycle E+MUL_LAT. Back-to-back issue sustained.
//  DIV FSM: IDLE -> PREP -> BUSY -> DONE -> IDLE.
//   IDLE: accept DIV op; latch tag, signs, funct3.
//   PREP (1 cyc): take abs values for signed ops; detect specials.
//    div-by-zero: q=all ones, r=dividend.
//    signed overflow (0x80000000 / -1): q=0x80000000, r=0.
//    On a special, result is loaded directly and PREP->DONE.
//   BUSY: exactly XLEN restoring iterations, 1 bit/cycle, 6-bit counter 0..31.
//    At count 31: sign-fix (q neg if signs differ, r takes dividend sign), then ->DONE.
//   DONE: hold result until the wb slot is free, then ->IDLE.
//   Normal latency: accepted at edge E -> earliest wb at cycle E+XLEN+2.
//   Special latency: earliest wb at cycle E+2.
//  Writeback arbitration:
//   The mul pipe head has absolute priority.
//   Div DONE drives wb only in cycles with no mul result. DONE may wait indefinitely.
//   Its state->IDLE in the same edge as its wb beat.
//  Result is lost nowhere: a mul collision stalls the div in DONE only.
//  Flush: at an edge with flush_i=1, clear all mul valid bits and force FSM->IDLE.
//   The same-cycle request is not accepted (ready=0).
//   wb_valid_o is still driven combinationally in the flush cycle; ROB discards it.
//  IDLE->PREP while a MUL is accepted in the same cycle is legal (one op per cycle).
// STRUCTURE
//  Shared package (muldiv_pkg): FUNCT3_* constants, XLEN, TAG_W,
//   div_state_t enum {IDLE,PREP,BUSY,DONE}.
//  Sub-module div_radix2_step: combinational one-bit restoring step
//   (rem,quo,divisor -> rem',quo'). FSM, counter and arbitration stay in muldiv_sched.
//  The multiplier product is an inferred 65-bit signed multiply in the last mul stage.
// TESTING
//  MUL 7*-3, tag 5, MUL_LAT=2, issue at edge 0 -> wb at cycle 2: tag 5, 0xFFFFFFEB.
//  MULH/MULHU/MULHSU with 0xFFFFFFFF x 0xFFFFFFFF issued back-to-back
//   -> three consecutive wb beats: 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF.
//  DIV -7/2 then REM -7/2 -> q=0xFFFFFFFD at cycle 34 after accept;
//   r=0xFFFFFFFF; req_ready_o=0 for DIV while busy.
//  DIVU x/0 -> 0xFFFFFFFF at cycle 2. REM 0x80000000 % -1 -> 0 at cycle 2.
//  Div reaches DONE while MULs are issued every cycle
//   -> div held (wb beats are all mul); div beat appears in the first mul-free cycle.
//  Flush mid-BUSY plus 2 muls in flight -> no wb next cycles; div_busy_o=0 after the edge.
//   A new DIV is accepted the cycle after the flush.
//   Reset asserted mid-BUSY gives the same result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state type and pipeline payload for the M-extension scheduler.
package muldiv_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned TAG_W  = 6;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned OPW    = XLEN + 1;     // operand widened by one sign/zero bit
   localparam int unsigned PROD_W = 2 * XLEN + 1; // signed product width
   localparam int unsigned DW     = 2 * XLEN;     // product bits actually consumed

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      BUSY = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // One multiplier pipeline slot; operands are pre-extended so the product is a plain signed multiply.
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic             hi_sel;
      logic [OPW-1:0]   a;
      logic [OPW-1:0]   b;
   } mul_stage_t;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring radix-2 division step: shift in the next dividend bit, subtract if it fits.
module div_radix2_step
   import muldiv_pkg::*;
(
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_dvs,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;

   // The quotient register doubles as the dividend shifter; its MSB feeds the partial remainder.
   assign w_shift = {i_rem, i_quo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, i_dvs};

   // A borrow in the top bit means the divisor did not fit: restore and shift in a zero.
   assign o_rem = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
   assign o_quo = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/muldiv_sched.sv
// Mul/div issue scheduler: pipelined multiplier plus iterative divider sharing one CDB port.
module muldiv_sched
   import muldiv_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [2:0]       funct3_i,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [XLEN-1:0]  rs2_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             wb_valid_o,
   output logic [TAG_W-1:0] wb_tag_o,
   output logic [XLEN-1:0]  wb_value_o,
   output logic             div_busy_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t       r_state;
   div_state_t       w_state_nxt;

   mul_stage_t       r_mul [MUL_LAT];
   mul_stage_t       w_mul_in;
   mul_stage_t       w_head;
   logic [DW-1:0]    w_prod;
   logic [XLEN-1:0]  w_mul_res;

   logic             w_is_div;
   logic             w_mul_acc;
   logic             w_div_acc;

   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_dvs;
   logic [XLEN-1:0]  r_result;
   logic [TAG_W-1:0] r_tag;
   logic             r_unsigned;
   logic             r_is_rem;
   logic             r_neg_q;
   logic             r_neg_r;

   logic [XLEN-1:0]  w_rem_n;
   logic [XLEN-1:0]  w_quo_n;
   logic             w_a_neg;
   logic             w_b_neg;
   logic             w_div_zero;
   logic             w_ovf;
   logic             w_special;
   logic [XLEN-1:0]  w_special_res;
   logic [XLEN-1:0]  w_fix_q;
   logic [XLEN-1:0]  w_fix_r;

   // Issue: MULs always go, DIVs only into an idle divider; nothing is taken during reset or flush.
   assign w_is_div    = funct3_i[2];
   assign req_ready_o = reset_i & ~flush_i & (~w_is_div | (r_state == IDLE));
   assign w_mul_acc   = req_valid_i & req_ready_o & ~w_is_div;
   assign w_div_acc   = req_valid_i & req_ready_o &  w_is_div;

   // Multiplier entry: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
   always_comb begin
      w_mul_in        = '0;
      w_mul_in.valid  = w_mul_acc;
      w_mul_in.tag    = tag_i;
      w_mul_in.hi_sel = (funct3_i[1:0] != 2'b00);
      w_mul_in.a      = {((funct3_i[1:0] == 2'b01) | (funct3_i[1:0] == 2'b10)) & rs1_i[XLEN-1], rs1_i};
      w_mul_in.b      = {(funct3_i[1:0] == 2'b01) & rs2_i[XLEN-1], rs2_i};
   end

   // Multiplier delay line; flush and reset only need to kill the valid bits.
   always_ff @(posedge clk_i) begin
      if (!reset_i || flush_i) begin
         for (int i = 0; i < int'(MUL_LAT); i++) begin
            r_mul[i].valid <= 1'b0;
         end
      end else begin
         r_mul[0] <= w_mul_in;
         for (int i = 1; i < int'(MUL_LAT); i++) begin
            r_mul[i] <= r_mul[i-1];
         end
      end
   end

   // Product formed at the pipe head; only the low 2*XLEN bits of the signed product are needed.
   assign w_head    = r_mul[MUL_LAT-1];
   assign w_prod    = DW'(PROD_W'($signed(w_head.a)) * PROD_W'($signed(w_head.b)));
   assign w_mul_res = w_head.hi_sel ? w_prod[DW-1:XLEN] : w_prod[XLEN-1:0];

   div_radix2_step u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_dvs (r_dvs),
      .o_rem (w_rem_n),
      .o_quo (w_quo_n)
   );

   // In PREP the quotient/divisor registers still hold the raw operands.
   assign w_a_neg    = ~r_unsigned & r_quo[XLEN-1];
   assign w_b_neg    = ~r_unsigned & r_dvs[XLEN-1];
   assign w_div_zero = (r_dvs == '0);
   assign w_ovf      = ~r_unsigned & (r_quo == INT_MIN) & (r_dvs == '1);
   assign w_special  = w_div_zero | w_ovf;

   // Special-case results: x/0 -> q=-1, r=x; INT_MIN/-1 -> q=INT_MIN, r=0.
   always_comb begin
      w_special_res = '0;
      if (w_div_zero) begin
         w_special_res = r_is_rem ? r_quo : '1;
      end else begin
         w_special_res = r_is_rem ? '0 : r_quo;
      end
   end

   // Sign fix applied to the final iteration's outputs.
   assign w_fix_q = r_neg_q ? (XLEN'(0) - w_quo_n) : w_quo_n;
   assign w_fix_r = r_neg_r ? (XLEN'(0) - w_rem_n) : w_rem_n;

   // Divider state register.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Divider next state; DONE yields to any multiplier result and flush overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (w_div_acc) w_state_nxt = PREP;
         PREP: w_state_nxt = w_special ? DONE : BUSY;
         BUSY: if (r_cnt == CNT_LAST) w_state_nxt = DONE;
         DONE: if (!w_head.valid) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (flush_i) begin
         w_state_nxt = IDLE;
      end
   end

   // Divider datapath: latch on accept, normalise in PREP, iterate in BUSY.
   always_ff @(posedge clk_i) begin
      case (r_state)
         IDLE: begin
            if (w_div_acc) begin
               r_quo      <= rs1_i;
               r_dvs      <= rs2_i;
               r_tag      <= tag_i;
               r_unsigned <= funct3_i[0];
               r_is_rem   <= funct3_i[1];
            end
         end
         PREP: begin
            r_rem   <= '0;
            r_cnt   <= '0;
            r_quo   <= w_a_neg ? (XLEN'(0) - r_quo) : r_quo;
            r_dvs   <= w_b_neg ? (XLEN'(0) - r_dvs) : r_dvs;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_special) begin
               r_result <= w_special_res;
            end
         end
         BUSY: begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
               r_result <= r_is_rem ? w_fix_r : w_fix_q;
            end
         end
         default: ;
      endcase
   end

   // CDB merge: the multiplier head always wins the slot.
   assign wb_valid_o = w_head.valid | (r_state == DONE);
   assign wb_tag_o   = w_head.valid ? w_head.tag : r_tag;
   assign wb_value_o = w_head.valid ? w_mul_res  : r_result;
   assign div_busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed scenarios plus a randomized run against a timing model.
module tb_muldiv_sched;
   import muldiv_pkg::*;

   localparam int unsigned LAT = 2;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic             flush_i;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [2:0]       funct3_i;
   logic [XLEN-1:0]  rs1_i;
   logic [XLEN-1:0]  rs2_i;
   logic [TAG_W-1:0] tag_i;
   logic             wb_valid_o;
   logic [TAG_W-1:0] wb_tag_o;
   logic [XLEN-1:0]  wb_value_o;
   logic             div_busy_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int               due;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  val;
   } ent_t;

   always #5 clk_i = ~clk_i;

   muldiv_sched #(.MUL_LAT(LAT)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .flush_i     (flush_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .funct3_i    (funct3_i),
      .rs1_i       (rs1_i),
      .rs2_i       (rs2_i),
      .tag_i       (tag_i),
      .wb_valid_o  (wb_valid_o),
      .wb_tag_o    (wb_tag_o),
      .wb_value_o  (wb_value_o),
      .div_busy_o  (div_busy_o)
   );

   // Drive one cycle of inputs after the falling edge, then let outputs settle for sampling.
   task automatic go(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [5:0] t, input logic fl = 1'b0, input logic rn = 1'b1);
      @(negedge clk_i);
      req_valid_i = v;
      funct3_i    = f;
      rs1_i       = a;
      rs2_i       = b;
      tag_i       = t;
      flush_i     = fl;
      reset_i     = rn;
      #1;
   endtask

   task automatic idle();
      go(1'b0, 3'b000, 32'd0, 32'd0, 6'd0);
   endtask

   // Architectural result of an M-extension op.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, za, zb, p;
      int ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      za = {32'd0, a};
      zb = {32'd0, b};
      ia = a;
      ib = b;
      p  = 64'd0;
      case (f)
         3'd0: begin p = za * zb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * zb; return p[63:32]; end
         3'd3: begin p = za * zb; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      repeat (3) go(1'b1, FUNCT3_DIV, 32'd5, 32'd1, 6'd1, 1'b0, 1'b0);
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready_o); end
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid_o); end
      checks++; if (div_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", div_busy_o); end
      idle();
      checks++; if (req_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
         errors++; $display("FAIL post_reset ready=%b wb_valid=%b exp 1/0", req_ready_o, wb_valid_o); end
   endtask

   task automatic test_mul_basic();
      go(1'b1, FUNCT3_MUL, 32'd7, -32'd3, 6'd5);
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mul_ready got %b exp 1", req_ready_o); end
      idle();
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL mul_early_wb got %b exp 0", wb_valid_o); end
      idle();
      checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd5 || wb_value_o !== 32'hFFFF_FFEB) begin
         errors++; $display("FAIL mul_basic got v=%b tag=%0d val=%h exp v=1 tag=5 val=ffffffeb", wb_valid_o, wb_tag_o, wb_value_o); end
      idle();
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL mul_after got %b exp 0", wb_valid_o); end
   endtask

   task automatic test_mul_hi_b2b();
      logic [31:0] exp_v [3];
      exp_v[0] = 32'h0000_0000;
      exp_v[1] = 32'hFFFF_FFFE;
      exp_v[2] = 32'hFFFF_FFFF;
      go(1'b1, FUNCT3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd11);
      go(1'b1, FUNCT3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12);
      go(1'b1, FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd13);
      for (int k = 0; k < 3; k++) begin
         checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'(11 + k) || wb_value_o !== exp_v[k]) begin
            errors++; $display("FAIL mul_hi_b2b[%0d] got v=%b tag=%0d val=%h exp tag=%0d val=%h",
                               k, wb_valid_o, wb_tag_o, wb_value_o, 11 + k, exp_v[k]); end
         idle();
      end
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL mul_hi_tail got %b exp 0", wb_valid_o); end
   endtask

   task automatic test_div_signed();
      go(1'b1, FUNCT3_DIV, -32'd7, 32'd2, 6'd9);
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL div_accept got %b exp 1", req_ready_o); end
      for (int k = 1; k <= 33; k++) begin
         go(1'b1, FUNCT3_REM, -32'd7, 32'd2, 6'd10);
         checks++; if (req_ready_o !== 1'b0 || wb_valid_o !== 1'b0 || div_busy_o !== 1'b1) begin
            errors++; $display("FAIL div_busy_cyc%0d got ready=%b wb=%b busy=%b exp 0/0/1", k, req_ready_o, wb_valid_o, div_busy_o); end
      end
      go(1'b1, FUNCT3_REM, -32'd7, 32'd2, 6'd10);
      checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd9 || wb_value_o !== 32'hFFFF_FFFD || req_ready_o !== 1'b0) begin
         errors++; $display("FAIL div_q got v=%b tag=%0d val=%h ready=%b exp 1/9/fffffffd/0", wb_valid_o, wb_tag_o, wb_value_o, req_ready_o); end
      go(1'b1, FUNCT3_REM, -32'd7, 32'd2, 6'd10);
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rem_accept got %b exp 1", req_ready_o); end
      repeat (34) idle();
      checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd10 || wb_value_o !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL rem_r got v=%b tag=%0d val=%h exp 1/10/ffffffff", wb_valid_o, wb_tag_o, wb_value_o); end
      idle();
   endtask

   task automatic test_div_special();
      go(1'b1, FUNCT3_DIVU, 32'd12345, 32'd0, 6'd3);
      idle();
      checks++; if (wb_valid_o !== 1'b0 || div_busy_o !== 1'b1) begin
         errors++; $display("FAIL divz_prep got wb=%b busy=%b exp 0/1", wb_valid_o, div_busy_o); end
      idle();
      checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd3 || wb_value_o !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL divu_by_zero got v=%b tag=%0d val=%h exp 1/3/ffffffff", wb_valid_o, wb_tag_o, wb_value_o); end
      idle();
      checks++; if (div_busy_o !== 1'b0) begin errors++; $display("FAIL divz_idle got %b exp 0", div_busy_o); end
      go(1'b1, FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd4);
      idle();
      idle();
      checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd4 || wb_value_o !== 32'd0) begin
         errors++; $display("FAIL rem_ovf got v=%b tag=%0d val=%h exp 1/4/0", wb_valid_o, wb_tag_o, wb_value_o); end
      idle();
   endtask

   task automatic test_div_vs_mul();
      go(1'b1, FUNCT3_DIVU, 32'd100, 32'd7, 6'd63);
      for (int i = 1; i <= 40; i++) begin
         go(1'b1, FUNCT3_MUL, 32'(i), 32'd3, 6'(i));
         if (i >= 3) begin
            checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'(i - 2) || wb_value_o !== 32'(3 * (i - 2)) || div_busy_o !== 1'b1) begin
               errors++; $display("FAIL div_held_cyc%0d got v=%b tag=%0d val=%h busy=%b exp tag=%0d val=%0d",
                                  i, wb_valid_o, wb_tag_o, wb_value_o, div_busy_o, i - 2, 3 * (i - 2)); end
         end
      end
      idle();
      idle();
      checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd40 || wb_value_o !== 32'd120) begin
         errors++; $display("FAIL last_mul got v=%b tag=%0d val=%h exp 1/40/120", wb_valid_o, wb_tag_o, wb_value_o); end
      idle();
      checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd63 || wb_value_o !== 32'd14) begin
         errors++; $display("FAIL div_released got v=%b tag=%0d val=%h exp 1/63/14", wb_valid_o, wb_tag_o, wb_value_o); end
      idle();
      checks++; if (wb_valid_o !== 1'b0 || div_busy_o !== 1'b0) begin
         errors++; $display("FAIL div_released_idle got wb=%b busy=%b exp 0/0", wb_valid_o, div_busy_o); end
   endtask

   // Kill mid-BUSY with two MULs in flight, via flush (use_rst=0) or reset (use_rst=1).
   task automatic test_kill(input bit use_rst);
      go(1'b1, FUNCT3_DIV, 32'd1000, 32'd3, 6'd20);
      repeat (8) idle();
      go(1'b1, FUNCT3_MUL, 32'd5, 32'd6, 6'd21);
      go(1'b1, FUNCT3_MUL, 32'd7, 32'd8, 6'd22);
      go(1'b1, FUNCT3_DIV, 32'd9, 32'd3, 6'd23, !use_rst, use_rst ? 1'b0 : 1'b1);
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL kill%0d_ready got %b exp 0", use_rst, req_ready_o); end
      if (!use_rst) begin
         checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd21 || wb_value_o !== 32'd30) begin
            errors++; $display("FAIL flush_cycle_wb got v=%b tag=%0d val=%h exp 1/21/30", wb_valid_o, wb_tag_o, wb_value_o); end
      end
      go(1'b1, FUNCT3_DIV, 32'd9, 32'd3, 6'd24);
      checks++; if (wb_valid_o !== 1'b0 || div_busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++; $display("FAIL kill%0d_after got wb=%b busy=%b ready=%b exp 0/0/1", use_rst, wb_valid_o, div_busy_o, req_ready_o); end
      idle();
      checks++; if (wb_valid_o !== 1'b0 || div_busy_o !== 1'b1) begin
         errors++; $display("FAIL kill%0d_next got wb=%b busy=%b exp 0/1", use_rst, wb_valid_o, div_busy_o); end
      repeat (32) idle();
      idle();
      checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 6'd24 || wb_value_o !== 32'd3) begin
         errors++; $display("FAIL kill%0d_newdiv got v=%b tag=%0d val=%h exp 1/24/3", use_rst, wb_valid_o, wb_tag_o, wb_value_o); end
      idle();
   endtask

   // Random traffic against a latency/priority model of the writeback port.
   task automatic test_random();
      ent_t             mq[$];
      ent_t             e;
      bit               dp = 1'b0;
      int               ddue = 0;
      logic [5:0]       dtag = '0;
      logic [31:0]      dval = '0;
      logic             v, fl, er, ev;
      logic [2:0]       f;
      logic [31:0]      a, b, evl;
      logic [5:0]       t, et;
      bit               mulhit, divhit;
      for (int now = 0; now < 3000; now++) begin
         v  = ($urandom_range(0, 1) == 1);
         f  = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         t  = 6'($urandom);
         fl = ($urandom_range(0, 63) == 0);
         go(v, f, a, b, t, fl);
         mulhit = (mq.size() > 0) && (mq[0].due == now);
         divhit = !mulhit && dp && (ddue <= now);
         ev  = mulhit | divhit;
         et  = mulhit ? mq[0].tag : dtag;
         evl = mulhit ? mq[0].val : dval;
         er  = !fl && (!f[2] || !dp);
         checks++; if (req_ready_o !== er) begin
            errors++; $display("FAIL rnd_ready@%0d got %b exp %b", now, req_ready_o, er); end
         checks++; if (div_busy_o !== dp) begin
            errors++; $display("FAIL rnd_busy@%0d got %b exp %b", now, div_busy_o, dp); end
         checks++; if (wb_valid_o !== ev) begin
            errors++; $display("FAIL rnd_wb_valid@%0d got %b exp %b", now, wb_valid_o, ev); end
         if (ev) begin
            checks++; if (wb_tag_o !== et || wb_value_o !== evl) begin
               errors++; $display("FAIL rnd_wb@%0d got tag=%0d val=%h exp tag=%0d val=%h", now, wb_tag_o, wb_value_o, et, evl); end
         end
         if (mulhit) void'(mq.pop_front());
         if (divhit) dp = 1'b0;
         if (fl) begin
            mq.delete();
            dp = 1'b0;
         end else if (v && er) begin
            if (!f[2]) begin
               e.due = now + int'(LAT);
               e.tag = t;
               e.val = ref_result(f, a, b);
               mq.push_back(e);
            end else begin
               dp   = 1'b1;
               ddue = now + (ref_special(f, a, b) ? 2 : int'(XLEN) + 2);
               dtag = t;
               dval = ref_result(f, a, b);
            end
         end
      end
   endtask

   initial begin
      reset_i     = 1'b0;
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      funct3_i    = 3'b000;
      rs1_i       = '0;
      rs2_i       = '0;
      tag_i       = '0;
      test_reset();
      test_mul_basic();
      test_mul_hi_b2b();
      test_div_signed();
      test_div_special();
      test_div_vs_mul();
      test_kill(1'b0);
      test_kill(1'b1);
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
